irq_prio_router: RTL
====================

Name: irq_prio_router

Overview:
Dock-side interrupt router, parametrised successor of the single-active router.
- Every tile INT channel carries a per-source route entry: enable, level/edge mode, 3-bit priority and CPU INT index.
- Each CPU INT line arbitrates and tracks its own active source independently, so up to NUM_CPU_INT interrupts can be in service at once.
- NMIs are routed per slot to CPU NMI pins.
- Per-line acks produce a slot_ack pulse plus a registered vector record for the Dock vector logic.
- Single clock domain; config bus runs on clk.

Parameters:
NUM_SLOTS, 5, tile slots
NUM_TILE_INT_CH, 2, maskable channels per slot; NUM_SRC = NUM_SLOTS*NUM_TILE_INT_CH
NUM_CPU_INT, 4, CPU INT lines (max 16)
NUM_CPU_NMI, 2, CPU NMI lines (max 16)
CFG_ADDR_WIDTH, 8, config address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
tile_int_req  in  NUM_SRC  maskable requests, active-high, index = slot*NUM_TILE_INT_CH+ch
tile_nmi_req  in  NUM_SLOTS  NMI requests, active-high level
irq_ack  in  NUM_CPU_INT  one-cycle ack pulse per CPU INT line
cpu_int  out  NUM_CPU_INT  registered INT outputs
cpu_nmi  out  NUM_CPU_NMI  registered NMI outputs
int_active  out  NUM_CPU_INT  line j has an active source
int_slot  out  NUM_CPU_INT*SLOT_W  packed active slot per line (SLOT_W=max(1,clog2 NUM_SLOTS)); 0 when inactive
slot_ack  out  NUM_SLOTS  one-cycle ack pulse to owning slot
ack_valid  out  1  one-cycle vector record strobe
ack_line  out  4  CPU line acked
ack_slot  out  SLOT_W  slot acked
ack_ch  out  CH_W  channel acked (CH_W=max(1,clog2 NUM_TILE_INT_CH))
cfg_wr_en, cfg_rd_en  in  1  config strobes
cfg_addr  in  CFG_ADDR_WIDTH  config address
cfg_wdata  in  32  write data
cfg_rdata  out  32  read data
cfg_rvalid  out  1  read data valid

Behaviour:
Reset: all outputs 0. All route entries 0 (disabled). Pending, active and edge-history registers cleared. Asynchronous assert, synchronous release to clk.

Config map:
- Address a < NUM_SRC: INT entry {[15] en, [14] edge, [10:8] prio, [3:0] cpu_idx}.
- NUM_SRC + s: NMI entry {[15] en, [3:0] nmi_idx}.
- NUM_SRC + NUM_SLOTS: read-only status {[31:16] int_active zero-extended, [15:0] reserved 0}.
- Unused bits write-ignored and read 0. Writes to unmapped addresses are ignored; reads of them return 0.
- cfg_rdata/cfg_rvalid are registered one cycle after cfg_rd_en; otherwise cfg_rvalid=0 and cfg_rdata=0.

Pending:
- Level mode: pend[i] = req & en, registered each cycle.
- Edge mode: pend[i] is set on a rising edge (req & ~req_prev) with en=1. It is cleared by an ack of its owning line, or when en=0.
- If set and clear coincide, set wins.

Arbitration, per line j:
- Candidates: pend[i] & en & cpu_idx==j & not active on any line.
- Winner: highest prio; ties go to lowest i.
- Evaluated only while line j is idle. The active source is registered, and cpu_int[j] follows the active register.
- Latency: request high before edge k → pend at edge k → cpu_int[j] at edge k+1.
- No preemption: a higher-priority pending source waits until release.

Release of line j:
- Level source: req low or en=0 releases at the next edge. A new winner may be latched on that same edge (back-to-back service, no idle cycle).
- Edge source: ack on j releases at the ack edge.
- cpu_idx rewritten to another line: releases at the next edge.
- cpu_idx >= NUM_CPU_INT: source never routed.

Ack:
- irq_ack[j] with line j active → at the next edge, slot_ack[slot]=1 and ack_valid=1 with line/slot/ch, each for one cycle.
- An ack on an idle line is ignored.
- Simultaneous acks on several lines: the lowest line index gets the ack_* record. slot_ack is the OR of all acked slots. Edge clears apply for all acked lines.

NMI:
- cpu_nmi[n] is the registered OR of tile_nmi_req[s] over all s with NMI entry en=1 and nmi_idx==n.
- nmi_idx >= NUM_CPU_NMI: dropped.
- Latency: 1 cycle.

Optional Feature:
IRQ_ROUTER_INPUT_SYNC_EN
- Defined: tile_int_req and tile_nmi_req pass through 2-flop synchronizers before all logic. All request-to-output latencies grow by 2 cycles; the 2-stage sync registers reset to 0.
- Undefined: inputs are used directly and are required to be clk-synchronous.

Test Plan:
- Route src 3 (slot1 ch1) level, prio 2, line 1; raise req → cpu_int=4'b0010 two edges later, int_slot[line1]=1; drop req → cpu_int=0 one edge later.
- Src 0 prio 1 and src 5 prio 6 both on line 0, raised together → src 5 served first; ack → slot_ack=5'b00100, ack_slot=2, ack_ch=1; drop src 5 → src 0 active with no idle cycle.
- Src 2 edge mode on line 2; pulse req 1 cycle → cpu_int[2] held; irq_ack[2] → cpu_int[2] low next edge, slot_ack[1] pulse; no re-fire without a new edge.
- Src 0 on line 0 and src 4 on line 3, both acked same cycle → slot_ack=5'b00101, ack_line=0, ack_valid single cycle.
- NMI slot 4 → idx 1; assert → cpu_nmi=2'b10 after 1 edge; write entry en=0 → cpu_nmi=0.
- Assert rst_n=0 mid-service (line 1 active, edge pend set) → all outputs 0 immediately; after release with the entry rewritten, no stale activity.

Source files
------------

// File: rtl/irq_prio_router.sv
// Dock-side interrupt router: per-source routing to independently arbitrated CPU INT lines plus NMI fan-in.
// Optional macro IRQ_ROUTER_INPUT_SYNC_EN adds 2-flop synchronizers on tile_int_req/tile_nmi_req.
module irq_prio_router #(
    parameter int unsigned NUM_SLOTS       = 5,
    parameter int unsigned NUM_TILE_INT_CH = 2,
    parameter int unsigned NUM_CPU_INT     = 4,
    parameter int unsigned NUM_CPU_NMI     = 2,
    parameter int unsigned CFG_ADDR_WIDTH  = 8,
    localparam int unsigned NUM_SRC = NUM_SLOTS * NUM_TILE_INT_CH,
    localparam int unsigned SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int unsigned CH_W    = (NUM_TILE_INT_CH > 1) ? $clog2(NUM_TILE_INT_CH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              tile_int_req,
    input  logic [NUM_SLOTS-1:0]            tile_nmi_req,
    input  logic [NUM_CPU_INT-1:0]          irq_ack,
    output logic [NUM_CPU_INT-1:0]          cpu_int,
    output logic [NUM_CPU_NMI-1:0]          cpu_nmi,
    output logic [NUM_CPU_INT-1:0]          int_active,
    output logic [NUM_CPU_INT*SLOT_W-1:0]   int_slot,
    output logic [NUM_SLOTS-1:0]            slot_ack,
    output logic                            ack_valid,
    output logic [3:0]                      ack_line,
    output logic [SLOT_W-1:0]               ack_slot,
    output logic [CH_W-1:0]                 ack_ch,
    input  logic                            cfg_wr_en,
    input  logic                            cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0]       cfg_addr,
    input  logic [31:0]                     cfg_wdata,
    output logic [31:0]                     cfg_rdata,
    output logic                            cfg_rvalid
);

    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic       en;
        logic       edge_mode;
        logic [2:0] prio;
        logic [3:0] idx;
    } int_route_t;

    typedef struct packed {
        logic       en;
        logic [3:0] idx;
    } nmi_route_t;

    typedef struct packed {
        logic              valid;
        logic [3:0]        line;
        logic [SLOT_W-1:0] slot;
        logic [CH_W-1:0]   ch;
    } ack_rec_t;

    int_route_t          int_cfg_q [NUM_SRC];
    int_route_t          int_cfg_d [NUM_SRC];
    nmi_route_t          nmi_cfg_q [NUM_SLOTS];
    nmi_route_t          nmi_cfg_d [NUM_SLOTS];
    logic [NUM_SRC-1:0]  pend_q, pend_d;
    logic [NUM_SRC-1:0]  req_prev_q;
    logic [NUM_CPU_INT-1:0] active_q, active_d;
    logic [SRC_W-1:0]    act_src_q  [NUM_CPU_INT];
    logic [SRC_W-1:0]    act_src_d  [NUM_CPU_INT];
    logic [SLOT_W-1:0]   act_slot_q [NUM_CPU_INT];
    logic [SLOT_W-1:0]   act_slot_d [NUM_CPU_INT];
    logic [CH_W-1:0]     act_ch_q   [NUM_CPU_INT];
    logic [CH_W-1:0]     act_ch_d   [NUM_CPU_INT];
    logic [NUM_SLOTS-1:0] slot_ack_q, slot_ack_d;
    ack_rec_t            ack_q, ack_d;
    logic [NUM_CPU_NMI-1:0] nmi_q, nmi_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    logic [NUM_SRC-1:0]     int_req;
    logic [NUM_SLOTS-1:0]   nmi_req;
    logic [NUM_CPU_INT-1:0] ack_eff;
    logic [NUM_CPU_INT-1:0] rel;
    logic [NUM_SRC-1:0]     src_busy;
    logic [NUM_SRC-1:0]     src_acked;
    logic                   win_vld  [NUM_CPU_INT];
    logic [SRC_W-1:0]       win_src  [NUM_CPU_INT];
    logic [2:0]             win_prio [NUM_CPU_INT];
    logic [SLOT_W-1:0]      win_slot [NUM_CPU_INT];
    logic [CH_W-1:0]        win_ch   [NUM_CPU_INT];
    logic                   unused_wdata;

`ifdef IRQ_ROUTER_INPUT_SYNC_EN
    logic [NUM_SRC-1:0]   int_sync1_q, int_sync2_q;
    logic [NUM_SLOTS-1:0] nmi_sync1_q, nmi_sync2_q;

    // Two-stage synchronizers for asynchronous tile requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_sync1_q <= '0;
            int_sync2_q <= '0;
            nmi_sync1_q <= '0;
            nmi_sync2_q <= '0;
        end else begin
            int_sync1_q <= tile_int_req;
            int_sync2_q <= int_sync1_q;
            nmi_sync1_q <= tile_nmi_req;
            nmi_sync2_q <= nmi_sync1_q;
        end
    end

    assign int_req = int_sync2_q;
    assign nmi_req = nmi_sync2_q;
`else
    assign int_req = tile_int_req;
    assign nmi_req = tile_nmi_req;
`endif

    assign ack_eff      = irq_ack & active_q;
    assign unused_wdata = ^{cfg_wdata[31:16], cfg_wdata[13:11], cfg_wdata[7:4]};

    // Which sources are currently in service, and which of those were acked this cycle
    always_comb begin
        src_busy  = '0;
        src_acked = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            for (int j = 0; j < int'(NUM_CPU_INT); j++) begin
                if (active_q[j] && act_src_q[j] == SRC_W'(i)) begin
                    src_busy[i] = 1'b1;
                    if (ack_eff[j]) src_acked[i] = 1'b1;
                end
            end
        end
    end

    // Release of the active source on each line
    always_comb begin
        rel = '0;
        for (int j = 0; j < int'(NUM_CPU_INT); j++) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (active_q[j] && act_src_q[j] == SRC_W'(i)) begin
                    rel[j] = !int_cfg_q[i].en
                           || int_cfg_q[i].idx != 4'(j)
                           || (int_cfg_q[i].edge_mode ? ack_eff[j] : !int_req[i]);
                end
            end
        end
    end

    // Per-line winner: highest priority, strict > keeps the lowest index on ties
    always_comb begin
        for (int j = 0; j < int'(NUM_CPU_INT); j++) begin
            win_vld[j]  = 1'b0;
            win_src[j]  = '0;
            win_prio[j] = '0;
            win_slot[j] = '0;
            win_ch[j]   = '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (pend_q[i] && int_cfg_q[i].en && int_cfg_q[i].idx == 4'(j) && !src_busy[i]
                    && (!win_vld[j] || int_cfg_q[i].prio > win_prio[j])) begin
                    win_vld[j]  = 1'b1;
                    win_src[j]  = SRC_W'(i);
                    win_prio[j] = int_cfg_q[i].prio;
                    win_slot[j] = SLOT_W'(i / int'(NUM_TILE_INT_CH));
                    win_ch[j]   = CH_W'(i % int'(NUM_TILE_INT_CH));
                end
            end
        end
    end

    // Next-state: config, pending, line ownership, ack record, NMI
    always_comb begin
        int_cfg_d  = int_cfg_q;
        nmi_cfg_d  = nmi_cfg_q;
        pend_d     = '0;
        active_d   = active_q;
        act_src_d  = act_src_q;
        act_slot_d = act_slot_q;
        act_ch_d   = act_ch_q;
        slot_ack_d = '0;
        ack_d      = '0;
        nmi_d      = '0;
        rdata_d    = '0;
        rvalid_d   = cfg_rd_en;

        if (cfg_wr_en) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (cfg_addr == CFG_ADDR_WIDTH'(i)) begin
                    int_cfg_d[i] = '{en: cfg_wdata[15], edge_mode: cfg_wdata[14],
                                     prio: cfg_wdata[10:8], idx: cfg_wdata[3:0]};
                end
            end
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                if (cfg_addr == CFG_ADDR_WIDTH'(int'(NUM_SRC) + s)) begin
                    nmi_cfg_d[s] = '{en: cfg_wdata[15], idx: cfg_wdata[3:0]};
                end
            end
        end

        if (cfg_rd_en) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (cfg_addr == CFG_ADDR_WIDTH'(i)) begin
                    rdata_d = {16'h0, int_cfg_q[i].en, int_cfg_q[i].edge_mode, 3'b000,
                               int_cfg_q[i].prio, 4'h0, int_cfg_q[i].idx};
                end
            end
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                if (cfg_addr == CFG_ADDR_WIDTH'(int'(NUM_SRC) + s)) begin
                    rdata_d = {16'h0, nmi_cfg_q[s].en, 11'h0, nmi_cfg_q[s].idx};
                end
            end
            if (cfg_addr == CFG_ADDR_WIDTH'(NUM_SRC + NUM_SLOTS)) begin
                rdata_d = {16'(active_q), 16'h0};
            end
        end

        // Edge pend: set beats clear; level pend simply tracks the request
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (int_cfg_q[i].edge_mode) begin
                pend_d[i] = (int_req[i] & ~req_prev_q[i] & int_cfg_q[i].en)
                          | (pend_q[i] & int_cfg_q[i].en & ~src_acked[i]);
            end else begin
                pend_d[i] = int_req[i] & int_cfg_q[i].en;
            end
        end

        for (int j = 0; j < int'(NUM_CPU_INT); j++) begin
            if (!active_q[j] || rel[j]) begin
                active_d[j]   = win_vld[j];
                act_src_d[j]  = win_src[j];
                act_slot_d[j] = win_slot[j];
                act_ch_d[j]   = win_ch[j];
            end
        end

        // Walk lines downward so the lowest acked line owns the record
        for (int j = int'(NUM_CPU_INT) - 1; j >= 0; j--) begin
            if (ack_eff[j]) begin
                ack_d = '{valid: 1'b1, line: 4'(j), slot: act_slot_q[j], ch: act_ch_q[j]};
                for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                    if (act_slot_q[j] == SLOT_W'(s)) slot_ack_d[s] = 1'b1;
                end
            end
        end

        for (int n = 0; n < int'(NUM_CPU_NMI); n++) begin
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                if (nmi_req[s] && nmi_cfg_q[s].en && nmi_cfg_q[s].idx == 4'(n)) nmi_d[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SRC); i++) int_cfg_q[i] <= '0;
            for (int s = 0; s < int'(NUM_SLOTS); s++) nmi_cfg_q[s] <= '0;
            for (int j = 0; j < int'(NUM_CPU_INT); j++) begin
                act_src_q[j]  <= '0;
                act_slot_q[j] <= '0;
                act_ch_q[j]   <= '0;
            end
            pend_q     <= '0;
            req_prev_q <= '0;
            active_q   <= '0;
            slot_ack_q <= '0;
            ack_q      <= '0;
            nmi_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            int_cfg_q  <= int_cfg_d;
            nmi_cfg_q  <= nmi_cfg_d;
            act_src_q  <= act_src_d;
            act_slot_q <= act_slot_d;
            act_ch_q   <= act_ch_d;
            pend_q     <= pend_d;
            req_prev_q <= int_req;
            active_q   <= active_d;
            slot_ack_q <= slot_ack_d;
            ack_q      <= ack_d;
            nmi_q      <= nmi_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    always_comb begin
        int_slot = '0;
        for (int j = 0; j < int'(NUM_CPU_INT); j++) begin
            int_slot[j*SLOT_W +: SLOT_W] = act_slot_q[j];
        end
    end

    assign cpu_int    = active_q;
    assign int_active = active_q;
    assign cpu_nmi    = nmi_q;
    assign slot_ack   = slot_ack_q;
    assign ack_valid  = ack_q.valid;
    assign ack_line   = ack_q.line;
    assign ack_slot   = ack_q.slot;
    assign ack_ch     = ack_q.ch;
    assign cfg_rdata  = rdata_q;
    assign cfg_rvalid = rvalid_q;

endmodule
